fifo_fwft_reader: RTL and testbench
===================================

// Module: fifo_fwft_reader
// PURPOSE
//  Read-side controller for the synchronous FIFO. Owns the read pointer, drives the read address of fifo_memory,
//  absorbs the memory's 1-cycle registered-read latency and presents a first-word-fall-through valid/ready stream.
//  A 2-entry output buffer (head + skid) sustains 1 word/cycle under continuous m_ready with no bubbles.
//  Counterpart of the write controller; the two share wr_ptr/rd_ptr for full/empty detection.
// PARAMETERS
//  DATA_WIDTH  16  word width; must match fifo_memory.DATA_WIDTH
//  DEPTH       16  memory words; power of two, >=2; AW = $clog2(DEPTH)
// PORTS
//  clk      in   1             rising-edge clock, single domain
//  rst      in   1             synchronous reset, active-high
//  wr_ptr   in   AW+1          binary write pointer from write side; increments on the same edge the word is written
//  raddr    out  AW            to fifo_memory.raddr; = rd_ptr[AW-1:0], combinational from the register
//  rdata    in   DATA_WIDTH    from fifo_memory.rdata; = mem[raddr of previous cycle]
//  rd_ptr   out  AW+1          registered binary read pointer; returned to write side for full detection
//  m_valid  out  1             registered; head entry holds a word
//  m_data   out  DATA_WIDTH    registered; head word
//  m_ready  in   1             consumer accepts head when m_valid & m_ready (pop)
//  level    out  AW+2          registered; words not yet popped (memory + in-flight + buffer), 0..DEPTH+2
// BEHAVIOUR
//  Reset: rd_ptr=0, raddr=0, m_valid=0, m_data=0, level=0, skid empty, inflight=0. Write side resets on the same rst.
//  Reset mid-operation: all state above cleared next cycle; rdata returning from a pre-reset fetch is discarded.
//  mem_empty = (wr_ptr == rd_ptr), full AW+1-bit compare; MSB distinguishes wrap laps.
//  Storage count S = buf_cnt (0..2) + inflight (0..1); invariant S <= 2.
//  fetch (cycle n) = !mem_empty && (S - pop) < 2. On fetch: rd_ptr <= rd_ptr+1 (mod 2^(AW+1)), inflight <= 1;
//   else inflight <= 0. raddr equals the pre-increment rd_ptr, so memory captures that word at the end of n.
//  Cycle n+1: rdata valid, written into head if head empty or being popped with skid empty, else into skid.
//  Pop with skid full: skid moves to head. Pop plus arrival with skid full cannot occur (S <= 2).
//  Latency: wr_ptr change seen in cycle n with reader idle -> m_valid=1 in cycle n+2.
//  Throughput: S=2 and pop every cycle -> fetch every cycle, 1 word/cycle sustained.
//  m_ready=0: m_valid, m_data held stable; fetching stops once S=2. m_ready with m_valid=0 is ignored.
//  Order is strict FIFO across memory, head and skid. No combinational path m_ready -> m_valid/m_data.
//  Slot freeing: a slot is released when its fetch increments rd_ptr; memory read-first semantics make a
//   same-edge rewrite of that slot safe.
//  level_next = ((wr_ptr - rd_ptr_next) mod 2^(AW+1)) + buf_cnt_next + inflight_next, zero-extended to AW+2 bits.
//  wr_ptr is trusted: the write side never advances it more than DEPTH ahead of rd_ptr; no overflow checks here.
// TESTING (DEPTH=16, DATA_WIDTH=16, reference memory model attached)
//  1 Hold rst 3 cycles, wr_ptr=0 -> m_valid=0, m_data=0, rd_ptr=0, raddr=0, level=0; idle with m_ready=1 -> unchanged.
//  2 Write 16'hA5A5 to addr 0, wr_ptr 0->1 seen in cycle n -> rd_ptr=1 from n+1, m_valid=1 and m_data=16'hA5A5
//    in n+2; pop -> m_valid=0, level=0.
//  3 Write 16 words 0x0000..0x000F, m_ready=1 held -> 16 consecutive pops, no gaps after the first, data in order.
//  4 Write 5 words, m_ready=0 -> rd_ptr stops at 2, m_data=word0 held, level=5.
//    Raise m_ready -> words 0..4 on 5 consecutive cycles.
//  5 Stream 40 words with random m_ready -> rd_ptr wraps 31->0 (MSB toggles), no loss or duplication, level never > 18.
//  6 Assert rst for 1 cycle during streaming with m_valid=1 and a fetch in flight -> next cycle m_valid=0,
//    rd_ptr=0, level=0; stale rdata never appears on m_data.

Source files
------------

// File: rtl/fifo_fwft_reader_if.sv
// Valid/ready stream carrying words out of the FIFO read side.
// The master drives valid/data and the slave drives ready.
interface fifo_fwft_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (output m_valid, output m_data, input  m_ready);
  modport slave  (input  m_valid, input  m_data, output m_ready);
endinterface

// File: rtl/fifo_fwft_reader.sv
// FIFO read controller: owns rd_ptr and hides the registered-read latency of the memory.
// A head + skid buffer presents a first-word-fall-through stream at one word per cycle.
module fifo_fwft_reader #(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 16,
  localparam int AW         = $clog2(DEPTH),
  localparam int LW         = AW + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW:0]           wr_ptr,
  output logic [AW-1:0]         raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [AW:0]           rd_ptr,
  output logic [LW-1:0]         level,
  fifo_fwft_reader_if.master    strm
);

  typedef struct packed {
    logic                  vld;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t          head_q, head_d;
  entry_t          skid_q, skid_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            inflight_q, inflight_d;
  logic [LW-1:0]   level_q, level_d;

  logic            mem_empty;
  logic            pop;
  logic            fetch;
  logic [1:0]      buf_cnt, buf_cnt_d;
  logic [1:0]      occ_after_pop;
  logic [AW:0]     mem_cnt_d;

  // Fetch control: at most two words may be held or in flight at once.
  always_comb begin
    mem_empty     = (wr_ptr == rd_ptr_q);
    pop           = head_q.vld & strm.m_ready;
    buf_cnt       = {1'b0, head_q.vld} + {1'b0, skid_q.vld};
    occ_after_pop = buf_cnt + {1'b0, inflight_q} - {1'b0, pop};
    fetch         = !mem_empty && (occ_after_pop < 2'd2);
    rd_ptr_d      = fetch ? rd_ptr_q + 1'b1 : rd_ptr_q;
    inflight_d    = fetch;
  end

  // A word returning from memory goes to head when head is free (or leaving with
  // nothing behind it); otherwise it lands in skid. Skid always drains into head first.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    if (pop) begin
      if (skid_q.vld) begin
        head_d     = skid_q;
        skid_d.vld = 1'b0;
      end else begin
        head_d.vld = inflight_q;
        if (inflight_q) head_d.data = rdata;
      end
    end else if (inflight_q) begin
      if (!head_q.vld) head_d = '{vld: 1'b1, data: rdata};
      else             skid_d = '{vld: 1'b1, data: rdata};
    end
  end

  // Occupancy counts every word not yet handed to the consumer.
  always_comb begin
    buf_cnt_d = {1'b0, head_d.vld} + {1'b0, skid_d.vld};
    mem_cnt_d = wr_ptr - rd_ptr_d;
    level_d   = LW'(mem_cnt_d) + LW'(buf_cnt_d) + LW'(inflight_d);
  end

  // Clearing inflight on reset drops any word still returning from a pre-reset fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      skid_q     <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      level_q    <= '0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      level_q    <= level_d;
    end
  end

  assign raddr        = rd_ptr_q[AW-1:0];
  assign rd_ptr       = rd_ptr_q;
  assign level        = level_q;
  assign strm.m_valid = head_q.vld;
  assign strm.m_data  = head_q.data;

endmodule

// File: tb/tb_fifo_fwft_reader.sv
// Bench for fifo_fwft_reader: reference memory + write side, scoreboard queue
// filled on every write, and a monitor that checks each popped word.
module tb_fifo_fwft_reader;
  localparam int DW = 16;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [AW:0]     wr_ptr;
  logic [AW-1:0]   raddr;
  logic [DW-1:0]   rdata;
  logic [AW:0]     rd_ptr;
  logic [AW+1:0]   level;
  logic            we = 1'b0;
  logic [DW-1:0]   wdata = '0;
  logic [DW-1:0]   mem [DEPTH];
  int              cyc = 0;

  int              total = 0;
  int              bad = 0;
  int              pops = 0;
  int              lvl_max = 0;
  logic [DW-1:0]   sb [$];
  int              pop_cyc [$];

  fifo_fwft_reader_if #(.DATA_WIDTH(DW)) m_if ();

  fifo_fwft_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_ptr (wr_ptr),
    .raddr  (raddr),
    .rdata  (rdata),
    .rd_ptr (rd_ptr),
    .level  (level),
    .strm   (m_if)
  );

  always #5 clk = ~clk;

  // Reference memory (registered, read-first) and write side.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rdata <= mem[raddr];
    if (rst) wr_ptr <= '0;
    else if (we) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (int'(level) > lvl_max) lvl_max = int'(level);
        if (m_if.m_valid && m_if.m_ready) begin
          pops++;
          pop_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: got %0h want none", m_if.m_data);
          end else begin
            e = sb.pop_front();
            chk("pop_data", m_if.m_data, e);
          end
        end
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    we = 1'b0;
    m_if.m_ready = 1'b0;
    sb.delete();
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic put(input logic [DW-1:0] d);
    we = 1'b1;
    wdata = d;
    sb.push_back(d);
    tick();
    we = 1'b0;
  endtask

  initial begin
    logic [AW:0] prev;
    bit wrapped;
    int n;
    int remaining;
    m_if.m_ready = 1'b0;
    fork monitor(); join_none

    // 1: reset state and idle
    do_reset(3);
    @(negedge clk);
    chk("rst_valid", m_if.m_valid, 0);
    chk("rst_data", m_if.m_data, 0);
    chk("rst_rdptr", rd_ptr, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_level", level, 0);
    tick();
    m_if.m_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("idle_valid", m_if.m_valid, 0);
    chk("idle_level", level, 0);
    chk("idle_rdptr", rd_ptr, 0);

    // 2: single word latency
    tick();
    m_if.m_ready = 1'b0;
    put(16'hA5A5);
    @(negedge clk);
    chk("lat_n_rdptr", rd_ptr, 0);
    chk("lat_n_valid", m_if.m_valid, 0);
    tick();
    @(negedge clk);
    chk("lat_n1_rdptr", rd_ptr, 1);
    chk("lat_n1_valid", m_if.m_valid, 0);
    tick();
    @(negedge clk);
    chk("lat_n2_valid", m_if.m_valid, 1);
    chk("lat_n2_data", m_if.m_data, 16'hA5A5);
    chk("lat_n2_level", level, 1);
    tick();
    m_if.m_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("lat_pop_valid", m_if.m_valid, 0);
    chk("lat_pop_level", level, 0);

    // 3: 16 words streamed, no bubbles
    do_reset(2);
    m_if.m_ready = 1'b1;
    pop_cyc.delete();
    we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata = DW'(i);
      sb.push_back(DW'(i));
      tick();
    end
    we = 1'b0;
    repeat (8) tick();
    chk("str_pops", pop_cyc.size(), 16);
    if (pop_cyc.size() == 16) chk("str_span", pop_cyc[15] - pop_cyc[0], 15);
    chk("str_sb_empty", sb.size(), 0);
    @(negedge clk);
    chk("str_level", level, 0);

    // 4: backpressure then drain
    do_reset(2);
    for (int i = 0; i < 5; i++) put(DW'(16'h0100 + i));
    repeat (4) tick();
    @(negedge clk);
    chk("bp_rdptr", rd_ptr, 2);
    chk("bp_valid", m_if.m_valid, 1);
    chk("bp_data", m_if.m_data, 16'h0100);
    chk("bp_level", level, 5);
    tick();
    pop_cyc.delete();
    m_if.m_ready = 1'b1;
    repeat (8) tick();
    chk("bp_pops", pop_cyc.size(), 5);
    if (pop_cyc.size() == 5) chk("bp_span", pop_cyc[4] - pop_cyc[0], 4);
    chk("bp_sb_empty", sb.size(), 0);

    // 5: 40 words, full memory, random ready, pointer wrap
    do_reset(2);
    pops = 0;
    lvl_max = 0;
    n = 0;
    remaining = 40;
    wrapped = 0;
    prev = rd_ptr;
    for (int c = 0; c < 30; c++) begin
      if (remaining > 0 && 5'(wr_ptr - rd_ptr) < 5'd16) begin
        we = 1'b1; wdata = DW'(16'h5000 + n); sb.push_back(wdata); n++; remaining--;
      end else we = 1'b0;
      tick();
    end
    we = 1'b0;
    @(negedge clk);
    chk("full_level", level, 18);
    chk("full_rdptr", rd_ptr, 2);
    chk("full_head", m_if.m_data, 16'h5000);
    for (int c = 0; c < 1000 && pops < 40; c++) begin
      tick();
      m_if.m_ready = 1'($urandom_range(0, 1));
      if (prev == 5'd31 && rd_ptr == 5'd0) wrapped = 1;
      prev = rd_ptr;
      if (remaining > 0 && 5'(wr_ptr - rd_ptr) < 5'd16) begin
        we = 1'b1; wdata = DW'(16'h5000 + n); sb.push_back(wdata); n++; remaining--;
      end else we = 1'b0;
    end
    we = 1'b0;
    m_if.m_ready = 1'b1;
    repeat (4) tick();
    chk("rnd_pops", pops, 40);
    chk("rnd_wrapped", wrapped, 1);
    chk("rnd_lvl_le18", lvl_max <= 18, 1);
    chk("rnd_sb_empty", sb.size(), 0);
    @(negedge clk);
    chk("rnd_rdptr", rd_ptr, 8);
    chk("rnd_level", level, 0);

    // 6: reset in the middle of streaming
    do_reset(2);
    m_if.m_ready = 1'b1;
    we = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wdata = DW'(16'h0600 + i);
      sb.push_back(wdata);
      tick();
    end
    we = 1'b0;
    @(negedge clk);
    chk("mid_pre_valid", m_if.m_valid, 1);
    tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_valid", m_if.m_valid, 0);
    chk("mid_rdptr", rd_ptr, 0);
    chk("mid_level", level, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("mid_stale", m_if.m_valid, 0);
    end
    tick();
    put(16'hBEEF);
    repeat (4) tick();
    chk("mid_sb_empty", sb.size(), 0);
    @(negedge clk);
    chk("mid_end_level", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
